// File: rtl/alu_multicycle_pkg.sv
// Shared ALU definitions: op codes emitted by the ALU control decoder and the
// execution-unit state encoding. Both blocks import this so the codes stay in step.
package alu_defs;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_BAD = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Start/busy/done handshake between the main control FSM (master) and the
// multi-cycle ALU (slave).
interface alu_multicycle_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [2:0]         ALUOperation;
    logic [WIDTH-1:0]   src1;
    logic [WIDTH-1:0]   src2;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               overflow;
    logic               invalid_op;

    modport master (
        output start, ALUOperation, src1, src2, shamt,
        input  busy, done, result, zero, overflow, invalid_op
    );

    modport slave (
        input  start, ALUOperation, src1, src2, shamt,
        output busy, done, result, zero, overflow, invalid_op
    );
endinterface

// File: rtl/alu_multicycle_comb.sv
// Single-cycle ALU datapath: add/sub/and/or/slt with signed overflow for add/sub.
module alu_comb
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             overflow
);
    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
        assign and_bits[gi] = a[gi] & b[gi];
        assign or_bits[gi]  = a[gi] | b[gi];
    end

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        y        = '0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                y        = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                y        = diff;
                // Subtraction adds -b, so the operand signs must differ to overflow.
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: y = and_bits;
            ALU_OR:  y = or_bits;
            ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU: single-cycle ops finish in one cycle, sll/srl shift
// one bit per cycle. Handshake is start/busy/done with the main control FSM.
module alu_multicycle
    import alu_defs::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    alu_multicycle_if.slave bus
);
    state_t             state_reg, state_next;
    logic [SHAMT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0]   shreg_reg, shreg_next;
    logic               dir_reg, dir_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               zero_reg, zero_next;
    logic               ovf_reg, ovf_next;
    logic               inv_reg, inv_next;

    logic [WIDTH-1:0]   comb_y;
    logic               comb_ovf;
    logic [WIDTH-1:0]   shifted;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op       (bus.ALUOperation),
        .a        (bus.src1),
        .b        (bus.src2),
        .y        (comb_y),
        .overflow (comb_ovf)
    );

    assign shifted = dir_reg ? (shreg_reg >> 1) : (shreg_reg << 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            shreg_reg  <= '0;
            dir_reg    <= 1'b0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            inv_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            shreg_reg  <= shreg_next;
            dir_reg    <= dir_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            ovf_reg    <= ovf_next;
            inv_reg    <= inv_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        shreg_next  = shreg_reg;
        dir_next    = dir_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        ovf_next    = ovf_reg;
        inv_next    = inv_reg;
        case (state_reg)
            S_SHIFT: begin
                shreg_next = shifted;
                count_next = count_reg - SHAMT_W'(1);
                if (count_reg == SHAMT_W'(1)) begin
                    state_next  = S_DONE;
                    result_next = shifted;
                    zero_next   = (shifted == '0);
                    ovf_next    = 1'b0;
                    inv_next    = 1'b0;
                end
            end
            default: begin
                // IDLE and DONE both accept a new op, giving back-to-back issue.
                state_next = S_IDLE;
                if (bus.start) begin
                    if (is_shift(bus.ALUOperation) && (bus.shamt != '0)) begin
                        state_next = S_SHIFT;
                        count_next = bus.shamt;
                        shreg_next = bus.src2;
                        dir_next   = (bus.ALUOperation == ALU_SRL);
                    end else begin
                        state_next = S_DONE;
                        ovf_next   = 1'b0;
                        inv_next   = 1'b0;
                        if (is_shift(bus.ALUOperation)) begin
                            result_next = bus.src2;
                        end else if (bus.ALUOperation == ALU_BAD) begin
                            result_next = '0;
                            inv_next    = 1'b1;
                        end else begin
                            result_next = comb_y;
                            ovf_next    = comb_ovf;
                        end
                        zero_next = (result_next == '0);
                    end
                end
            end
        endcase
    end

    assign bus.busy       = (state_reg == S_SHIFT);
    assign bus.done       = (state_reg == S_DONE);
    assign bus.result     = result_reg;
    assign bus.zero       = zero_reg;
    assign bus.overflow   = ovf_reg;
    assign bus.invalid_op = inv_reg && (state_reg == S_DONE);
endmodule
